line_mode_planner: RTL and testbench
====================================

Name: line_mode_planner

Overview:
- Produces the `mode`/`lastMode` command pair consumed by the two-wheel motor driver.
- Samples the 3-bit IR line sensor and the route command from the top-level controller.
- Filters the sensor, runs the start countdown, tracks the line, and handles junctions, turns, stop and lost-line error.
- Runs at 100 MHz in the car top level, between the sensor front end and the motor block.

Parameters:
- FILTER_CYCLES, 16, consecutive identical raw samples required before the filtered sensor updates.
- COUNT_CYCLES, 300_000_000, cycles spent in COUNT (3 s) before driving.
- TURN_CYCLES, 20_000_000, minimum cycles held in LEFT/RIGHT before the exit check.
- LOST_CYCLES, 50_000_000, cycles of continuous filtered 000 (or of turn time) before ERROR.

Ports:
- clk  input  1  100 MHz system clock
- rst  input  1  synchronous active-high reset
- start  input  1  level from the start button; the rising edge is detected internally
- sensor  input  3  raw {L,M,R}; 1 = line seen
- turn_cmd  input  2  action at the next junction: 00 straight, 01 left, 10 right, 11 stop
- mode  output  5  current command (encodings below), registered
- lastMode  output  5  mode just exited, valid one cycle after each transition; else 5'd0
- junction_cnt  output  4  junctions entered since START, saturates at 15

Behaviour:
- Reset and synchronicity: one clock domain; reset is synchronous and active-high.
- Reset values: mode=IDLE, lastMode=0, junction_cnt=0, filtered sensor=010, all counters 0, start edge register 0.
- Encodings: IDLE 0, START 1, COUNT 2, STRAIGHT 3, CHOOSE 4, LEFT 5, RIGHT 6, LITTLE_LEFT 8, LITTLE_RIGHT 9, STOP 30, ERROR 31. BACK (7) is never emitted.
- Sensor filter:
  - The raw sensor passes through 2 flops.
  - The filtered value updates once the synced value has been stable for FILTER_CYCLES cycles.
  - Any change restarts the stability count.
- Transitions use the filtered sensor s. Each transition takes effect on the next clock edge.
- lastMode:
  - The cycle after a transition, lastMode = previous mode.
  - Otherwise lastMode = 0.
  - Self-transitions are not transitions.
- IDLE: on a start rising edge -> START.
- START: one cycle; clear junction_cnt -> COUNT.
- COUNT: counter loaded with 0 at entry; after exactly COUNT_CYCLES cycles in COUNT -> STRAIGHT.
- Tracking states (STRAIGHT, LITTLE_LEFT, LITTLE_RIGHT):
  - s=010 -> STRAIGHT.
  - s=110 or 100 -> LITTLE_LEFT.
  - s=011 or 001 -> LITTLE_RIGHT.
  - s=111 -> CHOOSE.
  - s=101 -> hold.
  - s=000 -> hold, with the lost counter running; reaching LOST_CYCLES -> ERROR.
  - Any non-000 s clears the lost counter.
- CHOOSE:
  - On entry, latch turn_cmd and increment junction_cnt (saturating).
  - Hold while s=111.
  - When s≠111, go by the latched command: 00->STRAIGHT, 01->LEFT, 10->RIGHT, 11->STOP.
  - A turn_cmd change during CHOOSE is ignored.
- LEFT/RIGHT:
  - Turn counter starts at entry.
  - After TURN_CYCLES, s=010 -> STRAIGHT.
  - If the turn counter reaches LOST_CYCLES first -> ERROR.
  - LOST_CYCLES >= TURN_CYCLES is required; otherwise ERROR wins.
- STOP/ERROR: hold; on a start rising edge -> START.
- Simultaneous events:
  - ERROR timeout has priority over all sensor decisions in the same cycle.
  - A start edge outside IDLE/STOP/ERROR is ignored.
- Reset mid-operation: returns to IDLE on the next edge from any state. lastMode is forced to 0, not IDLE-exit reporting.
- Counter widths: wide enough for the largest parameter (30 bits at defaults). No wrap is allowed; counters stop at their terminal value.

Test Plan:
Common bench parameters: FILTER_CYCLES=4, COUNT_CYCLES=20, TURN_CYCLES=10, LOST_CYCLES=30.
1. Startup: rst 2 cycles, then start pulse with sensor=010 -> mode IDLE(0) -> START(1) for 1 cycle -> COUNT(2) for 20 cycles -> STRAIGHT(3). lastMode=1 one cycle after COUNT entry, 2 one cycle after STRAIGHT entry, 0 otherwise.
2. Line-following: in STRAIGHT, sensor 110 held 4 cycles -> LITTLE_LEFT(8). A 2-cycle 011 glitch -> no change. 001 held -> LITTLE_RIGHT(9). 010 -> STRAIGHT(3).
3. Left turn at junction: turn_cmd=01, sensor 111 -> CHOOSE(4), junction_cnt=1. Sensor 000 -> LEFT(5). Sensor 010 at turn cycle 5 -> stays LEFT until cycle 10 -> STRAIGHT(3), lastMode=5 for exactly 1 cycle.
4. Stop at junction: turn_cmd=11 at a junction -> STOP(30) after 111 clears. Start edge -> START(1), junction_cnt cleared to 0.
5. Lost line: sensor 000 held in STRAIGHT -> ERROR(31) exactly 30 cycles after the filtered 000. A 010 at cycle 29 clears the lost counter -> stays STRAIGHT.
6. Reset mid-turn: rst asserted in RIGHT(6) -> next cycle mode=0, lastMode=0, junction_cnt=0. A start edge is then required to move.

Source files
------------

// File: rtl/line_mode_planner.sv
// rtl/line_mode_planner.sv - mode/lastMode planner for the two-wheel motor driver
// Filters the IR line sensor, runs the start countdown, tracks the line and handles junctions.
module line_mode_planner #(
  parameter int FILTER_CYCLES = 16,
  parameter int COUNT_CYCLES  = 300_000_000,
  parameter int TURN_CYCLES   = 20_000_000,
  parameter int LOST_CYCLES   = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] sensor,
  input  logic [1:0] turn_cmd,
  output logic [4:0] mode,
  output logic [4:0] lastMode,
  output logic [3:0] junction_cnt
);

  localparam logic [4:0] S_IDLE         = 5'd0;
  localparam logic [4:0] S_START        = 5'd1;
  localparam logic [4:0] S_COUNT        = 5'd2;
  localparam logic [4:0] S_STRAIGHT     = 5'd3;
  localparam logic [4:0] S_CHOOSE       = 5'd4;
  localparam logic [4:0] S_LEFT         = 5'd5;
  localparam logic [4:0] S_RIGHT        = 5'd6;
  localparam logic [4:0] S_LITTLE_LEFT  = 5'd8;
  localparam logic [4:0] S_LITTLE_RIGHT = 5'd9;
  localparam logic [4:0] S_STOP         = 5'd30;
  localparam logic [4:0] S_ERROR        = 5'd31;

  localparam int CNT_MAX_A = (COUNT_CYCLES > LOST_CYCLES) ? COUNT_CYCLES : LOST_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > TURN_CYCLES) ? CNT_MAX_A : TURN_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX) + 1;
  localparam int STAB_W    = $clog2(FILTER_CYCLES + 1);

  localparam logic [CNT_W-1:0]  COUNT_LAST = CNT_W'(COUNT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOST_LAST  = CNT_W'(LOST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(CNT_MAX);
  localparam logic [STAB_W-1:0] STAB_FULL  = STAB_W'(FILTER_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(FILTER_CYCLES - 1);

  logic [2:0]        r_sync1;
  logic [2:0]        r_sync2;
  logic [2:0]        r_cand;
  logic [2:0]        r_filt;
  logic [STAB_W-1:0] r_stab;

  logic [4:0]        r_mode;
  logic [4:0]        r_last;
  logic [3:0]        r_jcnt;
  logic [1:0]        r_cmd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_start_d;

  logic [4:0]        w_next;
  logic              w_start_rise;
  logic              w_lost_hit;
  logic              w_changing;
  logic              w_tracking;

  assign mode         = r_mode;
  assign lastMode     = r_last;
  assign junction_cnt = r_jcnt;

  // r_cand holds the synced value being qualified; r_filt only follows it after a full stable run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 3'b010;
      r_sync2 <= 3'b010;
      r_cand  <= 3'b010;
      r_filt  <= 3'b010;
      r_stab  <= '0;
    end else begin
      r_sync1 <= sensor;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_stab <= STAB_W'(1);
        if (FILTER_CYCLES <= 1) r_filt <= r_sync2;
      end else if (r_stab != STAB_FULL) begin
        r_stab <= r_stab + 1'b1;
        if (r_stab == STAB_LAST) r_filt <= r_cand;
      end
    end
  end

  assign w_start_rise = start & ~r_start_d;
  assign w_lost_hit   = (r_cnt == LOST_LAST);
  assign w_changing   = (w_next != r_mode);
  assign w_tracking   = (r_mode == S_STRAIGHT) || (r_mode == S_LITTLE_LEFT) ||
                        (r_mode == S_LITTLE_RIGHT);

  always_comb begin
    w_next = r_mode;
    case (r_mode)
      S_IDLE, S_STOP, S_ERROR: begin
        if (w_start_rise) w_next = S_START;
      end
      S_START: w_next = S_COUNT;
      S_COUNT: begin
        if (r_cnt == COUNT_LAST) w_next = S_STRAIGHT;
      end
      S_STRAIGHT, S_LITTLE_LEFT, S_LITTLE_RIGHT: begin
        case (r_filt)
          3'b000:         if (w_lost_hit) w_next = S_ERROR;
          3'b010:         w_next = S_STRAIGHT;
          3'b110, 3'b100: w_next = S_LITTLE_LEFT;
          3'b011, 3'b001: w_next = S_LITTLE_RIGHT;
          3'b111:         w_next = S_CHOOSE;
          default:        w_next = r_mode;
        endcase
      end
      S_CHOOSE: begin
        if (r_filt != 3'b111) begin
          case (r_cmd)
            2'b00:   w_next = S_STRAIGHT;
            2'b01:   w_next = S_LEFT;
            2'b10:   w_next = S_RIGHT;
            default: w_next = S_STOP;
          endcase
        end
      end
      S_LEFT, S_RIGHT: begin
        // Timeout beats the exit check so a too-short LOST_CYCLES always ends in ERROR.
        if (w_lost_hit) w_next = S_ERROR;
        else if ((r_cnt >= TURN_LAST) && (r_filt == 3'b010)) w_next = S_STRAIGHT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode    <= S_IDLE;
      r_last    <= 5'd0;
      r_jcnt    <= 4'd0;
      r_cmd     <= 2'b00;
      r_cnt     <= '0;
      r_start_d <= 1'b0;
    end else begin
      r_start_d <= start;
      r_mode    <= w_next;
      r_last    <= w_changing ? r_mode : 5'd0;

      if (r_mode == S_START) begin
        r_jcnt <= 4'd0;
      end else if ((w_next == S_CHOOSE) && (r_mode != S_CHOOSE)) begin
        r_cmd <= turn_cmd;
        if (r_jcnt != 4'hF) r_jcnt <= r_jcnt + 4'd1;
      end

      // One shared counter: countdown in COUNT, lost-line run while tracking, turn time in LEFT/RIGHT.
      if (w_changing) begin
        r_cnt <= '0;
      end else if ((r_mode == S_COUNT) || (r_mode == S_LEFT) || (r_mode == S_RIGHT)) begin
        if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
      end else if (w_tracking) begin
        if (r_filt != 3'b000) r_cnt <= '0;
        else if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_line_mode_planner.sv
// tb/tb_line_mode_planner.sv - directed bench for line_mode_planner with a cycle model
module tb_line_mode_planner;

  localparam int P_FILTER = 4;
  localparam int P_COUNT  = 20;
  localparam int P_TURN   = 10;
  localparam int P_LOST   = 30;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] sensor;
  logic [1:0] turn_cmd;
  logic [4:0] mode;
  logic [4:0] lastMode;
  logic [3:0] junction_cnt;

  int checks;
  int errors;
  int chk_en;

  int m_mode, m_last, m_jcnt, m_cmd, m_filt;
  int m_s1, m_s2, m_prev, m_run, m_in_state, m_zero_run, m_prev_start;

  line_mode_planner #(
    .FILTER_CYCLES(P_FILTER),
    .COUNT_CYCLES (P_COUNT),
    .TURN_CYCLES  (P_TURN),
    .LOST_CYCLES  (P_LOST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sensor      (sensor),
    .turn_cmd    (turn_cmd),
    .mode        (mode),
    .lastMode    (lastMode),
    .junction_cnt(junction_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode follows the rules as a table of conditions on time-in-state and zero-run length.
  always @(posedge clk) begin
    int nm;
    int zero;
    if (rst) begin
      m_mode = 0; m_last = 0; m_jcnt = 0; m_cmd = 0; m_filt = 2;
      m_s1 = 2; m_s2 = 2; m_prev = 2; m_run = 0;
      m_in_state = 1; m_zero_run = 0; m_prev_start = 0;
    end else begin
      nm   = m_mode;
      zero = (m_filt == 0) ? m_zero_run + 1 : 0;
      case (m_mode)
        0, 30, 31: if (start && (m_prev_start == 0)) nm = 1;
        1: nm = 2;
        2: if (m_in_state == P_COUNT) nm = 3;
        3, 8, 9: begin
          if (zero >= P_LOST) nm = 31;
          else if (m_filt == 2) nm = 3;
          else if (m_filt == 6 || m_filt == 4) nm = 8;
          else if (m_filt == 3 || m_filt == 1) nm = 9;
          else if (m_filt == 7) nm = 4;
        end
        4: if (m_filt != 7) nm = (m_cmd == 0) ? 3 : (m_cmd == 1) ? 5 : (m_cmd == 2) ? 6 : 30;
        5, 6: begin
          if (m_in_state >= P_LOST) nm = 31;
          else if (m_in_state >= P_TURN && m_filt == 2) nm = 3;
        end
        default: nm = 0;
      endcase
      if (m_mode == 1) m_jcnt = 0;
      if (nm == 4 && m_mode != 4) begin
        m_cmd  = int'(turn_cmd);
        m_jcnt = (m_jcnt < 15) ? m_jcnt + 1 : 15;
      end
      m_last     = (nm != m_mode) ? m_mode : 0;
      m_in_state = (nm != m_mode) ? 1 : m_in_state + 1;
      m_zero_run = (nm != m_mode) ? 0 : zero;
      m_mode     = nm;
      m_run  = (m_s2 == m_prev) ? m_run + 1 : 1;
      m_prev = m_s2;
      if (m_run >= P_FILTER) m_filt = m_s2;
      m_s2 = m_s1;
      m_s1 = int'(sensor);
      m_prev_start = start ? 1 : 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      if (chk_en != 0) begin
        chk("model_mode", int'(mode), m_mode);
        chk("model_lastMode", int'(lastMode), m_last);
        chk("model_junction_cnt", int'(junction_cnt), m_jcnt);
      end
    end
  endtask

  task automatic run_length(input int m, output int n);
    n = 1;
    while (n < 200) begin
      tick(1);
      if (int'(mode) == m) n++;
      else break;
    end
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; chk_en = 0;
    rst = 1'b1; start = 1'b0; sensor = 3'b010; turn_cmd = 2'b00;
    tick(2);
    chk_en = 1;
    chk("reset_mode", int'(mode), 0);
    chk("reset_lastMode", int'(lastMode), 0);
    chk("reset_junction_cnt", int'(junction_cnt), 0);
    rst = 1'b0;
    tick(3);
    chk("idle_hold", int'(mode), 0);

    start = 1'b1; tick(1);
    chk("start_state", int'(mode), 1);
    start = 1'b0; tick(1);
    chk("count_entry", int'(mode), 2);
    chk("last_after_start", int'(lastMode), 1);
    run_length(2, n);
    chk("count_length", n, P_COUNT);
    chk("straight_after_count", int'(mode), 3);
    chk("last_after_count", int'(lastMode), 2);
    tick(1);
    chk("last_clears", int'(lastMode), 0);

    sensor = 3'b110; tick(6);
    chk("filter_latency_hold", int'(mode), 3);
    tick(1);
    chk("little_left", int'(mode), 8);
    sensor = 3'b011; tick(2);
    sensor = 3'b110; tick(8);
    chk("glitch_ignored", int'(mode), 8);
    sensor = 3'b001; tick(7);
    chk("little_right", int'(mode), 9);
    sensor = 3'b010; tick(7);
    chk("back_straight", int'(mode), 3);

    turn_cmd = 2'b01; sensor = 3'b111; tick(7);
    chk("choose_left", int'(mode), 4);
    chk("junction_one", int'(junction_cnt), 1);
    turn_cmd = 2'b10;
    sensor = 3'b000; tick(4);
    sensor = 3'b010; tick(3);
    chk("left_turn", int'(mode), 5);
    chk("last_choose", int'(lastMode), 4);
    run_length(5, n);
    chk("left_length", n, P_TURN);
    chk("left_exit", int'(mode), 3);
    chk("last_left", int'(lastMode), 5);
    tick(1);
    chk("last_left_one_cycle", int'(lastMode), 0);

    turn_cmd = 2'b11; sensor = 3'b111; tick(7);
    chk("choose_stop", int'(mode), 4);
    chk("junction_two", int'(junction_cnt), 2);
    sensor = 3'b010; tick(7);
    chk("stop_state", int'(mode), 30);
    start = 1'b1; tick(1);
    chk("restart_from_stop", int'(mode), 1);
    start = 1'b0; tick(1);
    chk("restart_count", int'(mode), 2);
    chk("junction_cleared", int'(junction_cnt), 0);
    tick(P_COUNT);
    chk("restart_straight", int'(mode), 3);

    sensor = 3'b000; tick(6);
    tick(P_LOST - 1);
    chk("lost_not_yet", int'(mode), 3);
    tick(1);
    chk("lost_error", int'(mode), 31);
    chk("last_before_error", int'(lastMode), 3);
    sensor = 3'b010; start = 1'b1; tick(1);
    start = 1'b0; tick(P_COUNT + 1);
    chk("straight_again", int'(mode), 3);
    sensor = 3'b000; tick(6);
    tick(23);
    sensor = 3'b010; tick(7);
    chk("lost_cleared_29", int'(mode), 3);
    tick(40);
    chk("lost_stays_clear", int'(mode), 3);

    turn_cmd = 2'b10; sensor = 3'b111; tick(7);
    chk("choose_right", int'(mode), 4);
    chk("junction_after_restart", int'(junction_cnt), 1);
    sensor = 3'b000; tick(7);
    chk("right_turn", int'(mode), 6);
    tick(3);
    rst = 1'b1; tick(1);
    chk("midturn_reset_mode", int'(mode), 0);
    chk("midturn_reset_last", int'(lastMode), 0);
    chk("midturn_reset_junction", int'(junction_cnt), 0);
    rst = 1'b0; tick(10);
    chk("reset_needs_start", int'(mode), 0);
    sensor = 3'b010; start = 1'b1; tick(1);
    chk("start_after_reset", int'(mode), 1);
    start = 1'b0; tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
